// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default widths and packed stage payload shared by pipe_stage_reg and its bench
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int META_W_DEF = 1;
  localparam int CNT_W_DEF  = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [META_W_DEF-1:0] meta;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  function automatic stage_t make_stage(input logic [DATA_W_DEF-1:0] data,
                                        input logic [META_W_DEF-1:0] meta);
    stage_t s;
    s.data = data;
    s.meta = meta;
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one-entry valid+payload holding register with load/unload/clear
module pipe_skid_slot #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // An empty slot always holds zero so nothing stale can leak out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear || (unload && !load)) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - ready/valid pipeline register with stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int META_W = META_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [META_W-1:0] in_meta,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [META_W-1:0] out_meta,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int W = DATA_W + META_W;

  logic [W-1:0] in_pay;
  logic [W-1:0] out_pay;
  logic [W-1:0] next_pay;
  logic         next_valid;
  logic         stalled;
  logic         accept;

  assign in_pay  = {in_data, in_meta};
  assign stalled = out_valid & ~out_ready;
  assign accept  = in_valid & in_ready & ~flush;

`ifdef PIPE_STAGE_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         skid_load;
  logic         skid_unload;

  // Ready comes only from the skid register, so out_ready never reaches in_ready.
  assign in_ready    = reset & (flush | ~skid_valid);
  assign skid_load   = accept & stalled;
  assign skid_unload = ~stalled & skid_valid;

  pipe_skid_slot #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (flush),
    .load_data (in_pay),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  always_comb begin
    next_valid = accept;
    next_pay   = accept ? in_pay : '0;
    if (skid_valid) begin
      next_valid = 1'b1;
      next_pay   = skid_data;
    end
  end
`else
  assign in_ready = reset & (flush | out_ready | ~out_valid);

  always_comb begin
    next_valid = accept;
    next_pay   = accept ? in_pay : '0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pay   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pay   <= '0;
    end else if (!stalled) begin
      out_valid <= next_valid;
      out_pay   <= next_pay;
    end
  end

  assign {out_data, out_meta} = out_pay;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (either PIPE_STAGE_SKID_EN build)
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [0:0]  in_meta, out_meta;
  logic [15:0] stall_cnt;

  logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [63:0] s_in_data, s_out_data;
  logic [0:0]  s_in_meta, s_out_meta;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  stage_t sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_meta(in_meta), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_meta(out_meta), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_meta(s_in_meta), .flush(s_flush), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_meta(s_out_meta), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: inputs are stable here for the coming edge, so fire conditions are final.
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_beat", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          stage_t e;
          e = sb_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_meta", 64'(out_meta), 64'(e.meta));
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(make_stage(in_data, in_meta));
    end
  end

  typedef struct {
    logic   iv;
    stage_t in;
    logic   fl;
    logic   ev;
    stage_t eout;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] nxt;
  logic        acc;

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, make_stage(64'h10 + 64'(i), 1'(i % 2)), 1'b0, 1'b1,
                  make_stage(64'h10 + 64'(i), 1'(i % 2))};
    vecs[8]  = '{1'b0, make_stage(64'hDEAD, 1'b1), 1'b0, 1'b0, make_stage(64'h0, 1'b0)};
    vecs[9]  = '{1'b1, make_stage(64'h40, 1'b1),   1'b0, 1'b1, make_stage(64'h40, 1'b1)};
    vecs[10] = '{1'b1, make_stage(64'h41, 1'b1),   1'b1, 1'b0, make_stage(64'h0, 1'b0)};
    vecs[11] = '{1'b0, make_stage(64'h42, 1'b1),   1'b0, 1'b0, make_stage(64'h0, 1'b0)};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_meta = '0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_meta = '0; s_flush = 1'b0; s_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Streaming, bubble and flush-with-traffic table
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv;
      in_data  = vecs[i].in.data;
      in_meta  = vecs[i].in.meta;
      flush    = vecs[i].fl;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].eout.data);
      chk($sformatf("vec%0d_meta", i), 64'(out_meta), 64'(vecs[i].eout.meta));
    end
    flush = 1'b0;
    in_valid = 1'b0;
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Backpressure: hold 0x20 three cycles while a source keeps offering 0x21..0x23
    in_valid = 1'b1; in_data = 64'h20; in_meta = 1'b0;
    tick();
    chk("bp_load", out_data, 64'h20);
    nxt = 64'h21; in_data = nxt; out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1 acc = in_valid & in_ready;
      tick();
      if (acc) nxt = nxt + 64'd1;
      in_data = nxt;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, 64'h20);
      chk("bp_stall_cnt", 64'(stall_cnt), 64'(k));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 acc = in_valid & in_ready;
      tick();
      if (acc) nxt = nxt + 64'd1;
      if (nxt > 64'h23) in_valid = 1'b0;
      else in_data = nxt;
    end
    chk("bp_cnt_after", 64'(stall_cnt), 64'd3);
    chk("bp_drained", 64'(sb_q.size()), 64'd0);
    chk("bp_all_sent", nxt, 64'h24);

`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1; in_data = 64'h2F;
    tick();
    out_ready = 1'b0; in_data = 64'h30;
    #1 chk("skid_rdy_pre", 64'(in_ready), 64'd1);
    tick();
    chk("skid_rdy_fall", 64'(in_ready), 64'd0);
    chk("skid_hold", out_data, 64'h2F);
    in_data = 64'h31;
    tick();
    chk("skid_rdy_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("skid_first", out_data, 64'h30);
    chk("skid_rdy_back", 64'(in_ready), 64'd1);
    tick();
    chk("skid_second", out_data, 64'h31);
    in_valid = 1'b0;
    tick();
    chk("skid_empty", 64'(out_valid), 64'd0);
`endif

    // Flush while stalled: in_ready forced high, held beat and incoming beat both dropped
    in_valid = 1'b1; in_data = 64'h55; in_meta = 1'b1; out_ready = 1'b1;
    tick();
    chk("fl_load", out_data, 64'h55);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h56;
    #1 chk("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_data", out_data, 64'd0);
    chk("fl_meta", 64'(out_meta), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // Reset in the middle of a stall
    in_valid = 1'b1; in_data = 64'h50; in_meta = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rs_stalled", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_data", out_data, 64'd0);
    chk("rs_meta", 64'(out_meta), 64'd0);
    chk("rs_cnt", 64'(stall_cnt), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = 64'h99;
    tick();
    chk("rs_hold_rdy", 64'(in_ready), 64'd0);
    chk("rs_hold_valid", 64'(out_valid), 64'd0);
    reset = 1'b1; in_data = 64'h60; in_meta = 1'b0; out_ready = 1'b1;
    #1 chk("rs_resume_rdy", 64'(in_ready), 64'd1);
    tick();
    chk("rs_resume_data", out_data, 64'h60);
    in_valid = 1'b0;
    tick();

    // Saturating 4-bit stall counter
    s_in_valid = 1'b1; s_in_data = 64'h77;
    tick();
    s_in_valid = 1'b0;
    chk("sat_loaded", 64'(s_out_valid), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_cnt%0d", k), 64'(s_stall_cnt), 64'((k > 15) ? 15 : k));
    end
    chk("sat_hold", s_out_data, 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
